sopc_mem_arbiter: RTL and testbench

- Merges the CPU's instruction-fetch port and data load/store port onto one single-ported unified memory.
- Sits between cpu and the shared memory in the next-generation SoC top, replacing the separate instruction ROM and data RAM.
- Parametrised in address width, data width, memory wait states and fetch anti-starvation limit.
- Generates a pipeline stall while either CPU request is outstanding.

---
 rtl/sopc_mem_arbiter_pkg.sv | 24 ++
 rtl/sopc_mem_arbiter_if.sv | 43 ++++
 rtl/sopc_arb_prio.sv | 23 ++
 rtl/sopc_mem_arbiter.sv | 109 ++++++++++
 tb/tb_sopc_mem_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, grant owners
// and the SoC-wide enable/disable constants.
package sopc_mem_arbiter_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int CNT_W     = 4;
  localparam int MAX_WAIT  = (1 << CNT_W) - 1;
  localparam int STREAK_W  = 8;
  localparam int MAX_STARVE = (1 << STREAK_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

endpackage

// File: rtl/sopc_mem_arbiter_if.sv
// CPU fetch port, CPU data port and unified memory port as one bundle.
// master = the arbiter; slave = the CPU/memory side.
interface sopc_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              if_ce_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_inst_o;
  logic              if_ack_o;

  logic              d_ce_i;
  logic              d_we_i;
  logic [SEL_W-1:0]  d_sel_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_data_i;
  logic [DATA_W-1:0] d_data_o;
  logic              d_ack_o;

  logic              mem_ce_o;
  logic              mem_we_o;
  logic [SEL_W-1:0]  mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;

  logic              stall_o;

  modport master (
    input  if_ce_i, if_addr_i, d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i, mem_data_i,
    output if_inst_o, if_ack_o, d_data_o, d_ack_o,
    output mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o, stall_o
  );

  modport slave (
    output if_ce_i, if_addr_i, d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i, mem_data_i,
    input  if_inst_o, if_ack_o, d_data_o, d_ack_o,
    input  mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o, stall_o
  );

endinterface

// File: rtl/sopc_arb_prio.sv
// Combinational grant selector: data beats fetch unless the fetch has waited
// through STARVE_LIMIT consecutive data grants.
module sopc_arb_prio
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output grant_e              grant
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  always_comb begin
    // NOTE: default assignment first so every path drives grant (no latch).
    grant = GNT_IF;
    if (d_req) grant = GNT_D;
    if (STARVE_LIMIT != 0 && if_req && streak == LIMIT) grant = GNT_IF;
  end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Shares one single-ported memory between the CPU fetch and data ports,
// one access at a time, with registered memory-side outputs.
module sopc_mem_arbiter
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  sopc_mem_arbiter_if.master bus
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("sopc_mem_arbiter: WAIT_CYCLES must be 0..15");
  end
  if (DATA_W < 8 || DATA_W % 8 != 0 || ADDR_W < 1) begin : g_bad_width
    $error("sopc_mem_arbiter: DATA_W must be a multiple of 8, ADDR_W >= 1");
  end
  if (STARVE_LIMIT < 0 || STARVE_LIMIT > MAX_STARVE) begin : g_bad_starve
    $error("sopc_mem_arbiter: STARVE_LIMIT out of range");
  end

  localparam logic [CNT_W-1:0]    WAIT_LOAD  = CNT_W'(WAIT_CYCLES);
  localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(STARVE_LIMIT);

  state_e              state;
  grant_e              grant;
  grant_e              arb_grant;
  logic [CNT_W-1:0]    wait_cnt;
  logic [STREAK_W-1:0] streak;

  sopc_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .if_req (bus.if_ce_i),
    .d_req  (bus.d_ce_i),
    .streak (streak),
    .grant  (arb_grant)
  );

  assign bus.stall_o = (bus.if_ce_i & ~bus.if_ack_o) | (bus.d_ce_i & ~bus.d_ack_o);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      grant          <= GNT_IF;
      wait_cnt       <= '0;
      streak         <= '0;
      bus.if_inst_o  <= '0;
      bus.if_ack_o   <= DISABLE;
      bus.d_data_o   <= '0;
      bus.d_ack_o    <= DISABLE;
      bus.mem_ce_o   <= DISABLE;
      bus.mem_we_o   <= DISABLE;
      bus.mem_sel_o  <= '0;
      bus.mem_addr_o <= '0;
      bus.mem_data_o <= '0;
    end else begin
      // Acks are single-cycle pulses raised only on the ACCESS->RESP edge.
      bus.if_ack_o <= DISABLE;
      bus.d_ack_o  <= DISABLE;
      case (state)
        ST_IDLE: begin
          if (bus.if_ce_i || bus.d_ce_i) begin
            grant        <= arb_grant;
            wait_cnt     <= WAIT_LOAD;
            bus.mem_ce_o <= ENABLE;
            state        <= ST_ACCESS;
            if (arb_grant == GNT_D) begin
              bus.mem_we_o   <= bus.d_we_i;
              bus.mem_sel_o  <= bus.d_sel_i;
              bus.mem_addr_o <= bus.d_addr_i;
              bus.mem_data_o <= bus.d_data_i;
              // Streak only counts data grants that overtook a waiting fetch.
              if (bus.if_ce_i && streak != STREAK_SAT) streak <= streak + 1'b1;
            end else begin
              bus.mem_we_o   <= DISABLE;
              bus.mem_sel_o  <= '1;
              bus.mem_addr_o <= bus.if_addr_i;
              streak         <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            bus.mem_ce_o <= DISABLE;
            bus.mem_we_o <= DISABLE;
            state        <= ST_RESP;
            if (grant == GNT_IF) begin
              bus.if_inst_o <= bus.mem_data_i;
              bus.if_ack_o  <= ENABLE;
            end else begin
              if (!bus.mem_we_o) bus.d_data_o <= bus.mem_data_i;
              bus.d_ack_o <= ENABLE;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed bench for sopc_mem_arbiter: several configurations side by side,
// each exercised by a linear sequence of hand-computed steps.
module tb_sopc_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sopc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1  ();
  sopc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0a ();
  sopc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0b ();
  sopc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3  ();
  sopc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus15 ();

  sopc_mem_arbiter #(.WAIT_CYCLES(1),  .STARVE_LIMIT(4)) u_w1  (.clk(clk), .rst(rst), .bus(bus1));
  sopc_mem_arbiter #(.WAIT_CYCLES(0),  .STARVE_LIMIT(2)) u_s2  (.clk(clk), .rst(rst), .bus(bus0a));
  sopc_mem_arbiter #(.WAIT_CYCLES(0),  .STARVE_LIMIT(0)) u_s0  (.clk(clk), .rst(rst), .bus(bus0b));
  sopc_mem_arbiter #(.WAIT_CYCLES(3),  .STARVE_LIMIT(4)) u_w3  (.clk(clk), .rst(rst), .bus(bus3));
  sopc_mem_arbiter #(.WAIT_CYCLES(15), .STARVE_LIMIT(4)) u_w15 (.clk(clk), .rst(rst), .bus(bus15));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] order [6];
    string      exp_ord;
    int         n_ord;
    int         n_we;
    int         n_if;
    int         n_d;
    int         got;
    int         ce_cnt;
    int         ack_cyc;

    bus1.if_ce_i = 0;  bus1.if_addr_i = '0;  bus1.d_ce_i = 0;  bus1.d_we_i = 0;
    bus1.d_sel_i = '0; bus1.d_addr_i = '0;   bus1.d_data_i = '0; bus1.mem_data_i = '0;
    bus0a.if_ce_i = 0; bus0a.if_addr_i = '0; bus0a.d_ce_i = 0; bus0a.d_we_i = 0;
    bus0a.d_sel_i = '0; bus0a.d_addr_i = '0; bus0a.d_data_i = '0; bus0a.mem_data_i = '0;
    bus0b.if_ce_i = 0; bus0b.if_addr_i = '0; bus0b.d_ce_i = 0; bus0b.d_we_i = 0;
    bus0b.d_sel_i = '0; bus0b.d_addr_i = '0; bus0b.d_data_i = '0; bus0b.mem_data_i = '0;
    bus3.if_ce_i = 0;  bus3.if_addr_i = '0;  bus3.d_ce_i = 0;  bus3.d_we_i = 0;
    bus3.d_sel_i = '0; bus3.d_addr_i = '0;   bus3.d_data_i = '0; bus3.mem_data_i = '0;
    bus15.if_ce_i = 0; bus15.if_addr_i = '0; bus15.d_ce_i = 0; bus15.d_we_i = 0;
    bus15.d_sel_i = '0; bus15.d_addr_i = '0; bus15.d_data_i = '0; bus15.mem_data_i = '0;

    // Reset state
    rst = 1'b1;
    #1 rst = 1'b0;
    step();
    step();
    check("rst_mem_ce",  bus1.mem_ce_o,   1'b0);
    check("rst_mem_we",  bus1.mem_we_o,   1'b0);
    check("rst_mem_sel", bus1.mem_sel_o,  4'h0);
    check("rst_mem_adr", bus1.mem_addr_o, 32'h0);
    check("rst_if_ack",  bus1.if_ack_o,   1'b0);
    check("rst_d_ack",   bus1.d_ack_o,    1'b0);
    check("rst_if_inst", bus1.if_inst_o,  32'h0);
    check("rst_d_data",  bus1.d_data_o,   32'h0);
    check("rst_stall",   bus1.stall_o,    1'b0);
    rst = 1'b1;

    // Fetch only, WAIT_CYCLES=1: ack in cycle 3
    step();
    bus1.if_ce_i = 1; bus1.if_addr_i = 32'h4; bus1.mem_data_i = 32'h3C010001;
    #1 check("t1_stall_c0", bus1.stall_o, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      step();
      check("t1_if_ack", bus1.if_ack_o, 1'(c == 3));
      check("t1_we",     bus1.mem_we_o, 1'b0);
      check("t1_stall",  bus1.stall_o,  1'(c != 3));
      if (c == 1) begin
        check("t1_mem_ce",  bus1.mem_ce_o,   1'b1);
        check("t1_mem_adr", bus1.mem_addr_o, 32'h4);
        check("t1_mem_sel", bus1.mem_sel_o,  4'hF);
      end
    end
    check("t1_inst", bus1.if_inst_o, 32'h3C010001);
    bus1.if_ce_i = 0;
    step();
    check("t1_ack_pulse", bus1.if_ack_o, 1'b0);
    check("t1_inst_hold", bus1.if_inst_o, 32'h3C010001);

    // Data write with byte select
    bus1.d_ce_i = 1; bus1.d_we_i = 1; bus1.d_sel_i = 4'b0010;
    bus1.d_addr_i = 32'h100; bus1.d_data_i = 32'hAABBCCDD; bus1.mem_data_i = 32'h11111111;
    n_we = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (bus1.mem_we_o) n_we++;
      if (c == 1) begin
        check("t2_mem_sel",  bus1.mem_sel_o,  4'b0010);
        check("t2_mem_adr",  bus1.mem_addr_o, 32'h100);
        check("t2_mem_data", bus1.mem_data_o, 32'hAABBCCDD);
      end
      check("t2_d_ack", bus1.d_ack_o, 1'(c == 3));
      if (c == 3) bus1.d_ce_i = 0;
    end
    check("t2_we_cycles", 64'(n_we), 64'd2);
    check("t2_d_data_kept", bus1.d_data_o, 32'h0);

    // Simultaneous fetch + data read, WAIT_CYCLES=0
    step();
    bus0a.if_ce_i = 1; bus0a.if_addr_i = 32'h40;
    bus0a.d_ce_i = 1; bus0a.d_we_i = 0; bus0a.d_sel_i = 4'hF; bus0a.d_addr_i = 32'h200;
    bus0a.mem_data_i = 32'hDEADBEEF;
    #1 check("t3_stall_c0", bus0a.stall_o, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      step();
      check("t3_d_ack",  bus0a.d_ack_o,  1'(c == 2));
      check("t3_if_ack", bus0a.if_ack_o, 1'(c == 5));
      check("t3_stall",  bus0a.stall_o,  1'(c < 5));
      if (c == 1) check("t3_first_adr", bus0a.mem_addr_o, 32'h200);
      if (c == 2) begin
        check("t3_d_data", bus0a.d_data_o, 32'hDEADBEEF);
        bus0a.d_ce_i = 0;
      end
      if (c == 3) bus0a.mem_data_i = 32'h12345678;
      if (c == 4) begin
        check("t3_second_adr", bus0a.mem_addr_o, 32'h40);
        check("t3_second_sel", bus0a.mem_sel_o,  4'hF);
      end
      if (c == 5) begin
        check("t3_inst", bus0a.if_inst_o, 32'h12345678);
        bus0a.if_ce_i = 0;
      end
    end

    // Starvation guard, STARVE_LIMIT=2: D D IF D D IF
    bus0a.if_ce_i = 1; bus0a.d_ce_i = 1;
    n_ord = 0;
    for (int c = 1; c <= 30 && n_ord < 6; c++) begin
      step();
      if (bus0a.d_ack_o) begin
        order[n_ord] = "D";
        n_ord++;
      end else if (bus0a.if_ack_o) begin
        order[n_ord] = "I";
        n_ord++;
      end
    end
    bus0a.if_ce_i = 0; bus0a.d_ce_i = 0;
    exp_ord = "DDIDDI";
    for (int i = 0; i < 6; i++) check($sformatf("t4_order%0d", i), order[i], exp_ord[i]);

    // STARVE_LIMIT=0: fetch never granted while data stays high
    step();
    bus0b.if_ce_i = 1; bus0b.if_addr_i = 32'h8;
    bus0b.d_ce_i = 1; bus0b.d_sel_i = 4'hF; bus0b.d_addr_i = 32'h20;
    n_if = 0; n_d = 0;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (bus0b.if_ack_o) n_if++;
      if (bus0b.d_ack_o)  n_d++;
    end
    bus0b.d_ce_i = 0;
    check("t5_if_acks", 64'(n_if), 64'd0);
    check("t5_d_acks",  64'(n_d),  64'd8);
    got = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus0b.if_ack_o) begin
        got = c;
        break;
      end
    end
    bus0b.if_ce_i = 0;
    check("t5_fetch_after_release", 64'(got), 64'd2);

    // Asynchronous reset mid-access, WAIT_CYCLES=3
    step();
    bus3.d_ce_i = 1; bus3.d_we_i = 0; bus3.d_sel_i = 4'hF; bus3.d_addr_i = 32'h300;
    bus3.mem_data_i = 32'hCAFEF00D;
    step();
    step();
    check("t6_in_access", bus3.mem_ce_o, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_rst_ce",   bus3.mem_ce_o,   1'b0);
    check("t6_rst_adr",  bus3.mem_addr_o, 32'h0);
    check("t6_rst_sel",  bus3.mem_sel_o,  4'h0);
    check("t6_rst_ack",  bus3.d_ack_o,    1'b0);
    check("t6_rst_data", bus3.d_data_o,   32'h0);
    step();
    check("t6_no_ack_in_rst", bus3.d_ack_o, 1'b0);
    rst = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      check("t6_d_ack", bus3.d_ack_o, 1'(c == 5));
    end
    check("t6_d_data", bus3.d_data_o, 32'hCAFEF00D);
    bus3.d_ce_i = 0;

    // WAIT_CYCLES=15 fetch: 16 enable cycles, ack in cycle 17
    step();
    bus15.if_ce_i = 1; bus15.if_addr_i = 32'h80; bus15.mem_data_i = 32'h0BADC0DE;
    ce_cnt = 0; ack_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus15.mem_ce_o) ce_cnt++;
      if (bus15.if_ack_o && ack_cyc < 0) begin
        ack_cyc = c;
        bus15.if_ce_i = 0;
      end
    end
    check("t7_ce_cycles", 64'(ce_cnt), 64'd16);
    check("t7_ack_cycle", 64'(ack_cyc), 64'd17);
    check("t7_inst", bus15.if_inst_o, 32'h0BADC0DE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
